// File: rtl/fpmul_unpack_pipe_if.sv
// Operand/result bundle for the FP multiply unpack stage.
// slave: the stage's view (operands in, results out). master: the producer/consumer view.
// Widths follow EXP_W/FRAC_W/TAG_W and must match the stage's parameters.
interface fpmul_unpack_pipe_if #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10,
    parameter int TAG_W  = 4
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      a_in;
    logic [W-1:0]      b_in;
    logic [TAG_W-1:0]  tag_in;
    logic              out_valid;
    logic              out_ready;
    logic              sign_out;
    logic [EXP_W+1:0]  exp_sum;
    logic [FRAC_W:0]   frac_a;
    logic [FRAC_W:0]   frac_b;
    logic              is_nan;
    logic              is_inf;
    logic              is_zero;
    logic [FRAC_W-1:0] nan_frac;
    logic [TAG_W-1:0]  tag_out;

    modport slave (
        input  in_valid, a_in, b_in, tag_in, out_ready,
        output in_ready, out_valid, sign_out, exp_sum, frac_a, frac_b,
               is_nan, is_inf, is_zero, nan_frac, tag_out
    );

    modport master (
        output in_valid, a_in, b_in, tag_in, out_ready,
        input  in_ready, out_valid, sign_out, exp_sum, frac_a, frac_b,
               is_nan, is_inf, is_zero, nan_frac, tag_out
    );
endinterface

// File: rtl/fpmul_unpack_pipe.sv
// Unpack/pre-multiply stage: sign, biased exponent sum, hidden-bit significands, special flags.
// Latency 1 cycle; full throughput via output register plus one skid register.
// in_ready = !skid_valid (registered only); optional macro FPMUL_UNPACK_FTZ_EN flushes denormal operands to zero.
module fpmul_unpack_pipe #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    fpmul_unpack_pipe_if.slave bus
);
    localparam int W    = 1 + EXP_W + FRAC_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic [EXP_W+1:0] BIAS_X = (EXP_W + 2)'(BIAS);

    typedef struct packed {
        logic              sign;
        logic [EXP_W+1:0]  exp_sum;
        logic [FRAC_W:0]   frac_a;
        logic [FRAC_W:0]   frac_b;
        logic              is_nan;
        logic              is_inf;
        logic              is_zero;
        logic [FRAC_W-1:0] nan_frac;
        logic [TAG_W-1:0]  tag;
    } res_t;

    // Field split
    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb, eff_a, eff_b;
    logic [FRAC_W-1:0] fa_raw, fb_raw, fa, fb;
    logic              inf_a, inf_b, nan_a, nan_b, zero_a, zero_b;
    logic              nan_r, inf_r;

    assign sa     = bus.a_in[W-1];
    assign sb     = bus.b_in[W-1];
    assign ea     = bus.a_in[W-2:FRAC_W];
    assign eb     = bus.b_in[W-2:FRAC_W];
    assign fa_raw = bus.a_in[FRAC_W-1:0];
    assign fb_raw = bus.b_in[FRAC_W-1:0];

`ifdef FPMUL_UNPACK_FTZ_EN
    // Denormals lose their fraction so they decode as signed zeros.
    assign fa = (ea == '0) ? '0 : fa_raw;
    assign fb = (eb == '0) ? '0 : fb_raw;
`else
    assign fa = fa_raw;
    assign fb = fb_raw;
`endif

    // Denormals (and zeros) use exponent 1 so the sum stays continuous.
    assign eff_a  = (ea == '0) ? EXP_W'(1) : ea;
    assign eff_b  = (eb == '0) ? EXP_W'(1) : eb;
    assign inf_a  = (&ea) & ~(|fa);
    assign inf_b  = (&eb) & ~(|fb);
    assign nan_a  = (&ea) & (|fa);
    assign nan_b  = (&eb) & (|fb);
    assign zero_a = ~(|ea) & ~(|fa);
    assign zero_b = ~(|eb) & ~(|fb);
    assign nan_r  = nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b);
    assign inf_r  = ~nan_r & (inf_a | inf_b);

    res_t nxt, out_q, skid_q;
    logic out_vld, skid_vld;
    logic in_xfer, out_xfer;

    // Build the result for the operands currently presented.
    always_comb begin
        nxt          = '0;
        nxt.sign     = sa ^ sb;
        // Two extra bits: one for the carry of the sum, one for the sign after removing the bias.
        nxt.exp_sum  = {2'b00, eff_a} + {2'b00, eff_b} - BIAS_X;
        nxt.frac_a   = {|ea, fa};
        nxt.frac_b   = {|eb, fb};
        nxt.is_nan   = nan_r;
        nxt.is_inf   = inf_r;
        nxt.is_zero  = ~nan_r & ~inf_r & (zero_a | zero_b);
        nxt.tag      = bus.tag_in;
        if (nan_a)
            nxt.nan_frac = {1'b1, fa[FRAC_W-2:0]};
        else if (nan_b)
            nxt.nan_frac = {1'b1, fb[FRAC_W-2:0]};
        else if (nan_r)
            nxt.nan_frac = {1'b1, {(FRAC_W-1){1'b0}}};
    end

    assign bus.in_ready = ~skid_vld;
    assign in_xfer      = bus.in_valid & ~skid_vld;
    assign out_xfer     = out_vld & bus.out_ready;

    // Output register: refilled from skid first, else from the new input, when empty or being taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (out_xfer || !out_vld) begin
            if (skid_vld) begin
                out_vld <= 1'b1;
                out_q   <= skid_q;
            end else if (in_xfer) begin
                out_vld <= 1'b1;
                out_q   <= nxt;
            end else begin
                out_vld <= 1'b0;
            end
        end
    end

    // Skid register: catches an accepted input while the output register is held; drains into it.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_vld <= 1'b0;
            skid_q   <= '0;
        end else if (out_xfer || !out_vld) begin
            skid_vld <= 1'b0;
        end else if (in_xfer) begin
            skid_vld <= 1'b1;
            skid_q   <= nxt;
        end
    end

    assign bus.out_valid = out_vld;
    assign bus.sign_out  = out_q.sign;
    assign bus.exp_sum   = out_q.exp_sum;
    assign bus.frac_a    = out_q.frac_a;
    assign bus.frac_b    = out_q.frac_b;
    assign bus.is_nan    = out_q.is_nan;
    assign bus.is_inf    = out_q.is_inf;
    assign bus.is_zero   = out_q.is_zero;
    assign bus.nan_frac  = out_q.nan_frac;
    assign bus.tag_out   = out_q.tag;
endmodule

// File: tb/tb_fpmul_unpack_pipe.sv
// Scoreboard bench for fpmul_unpack_pipe (FP16 defaults): directed vectors, backpressure,
// mid-stream reset and a long randomised-handshake run drawn from the same vector table.
module tb_fpmul_unpack_pipe;
    localparam int EXP_W = 5, FRAC_W = 10, TAG_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpmul_unpack_pipe_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) bus ();

    fpmul_unpack_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        sign;
        logic [6:0]  es;
        logic [10:0] fa, fb;
        logic        nan, inf, zero;
        logic [9:0]  nf;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic [3:0] tag;
    } exp_t;

    vec_t vecs[10];
    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   rand_rdy = 0;
    bit   stall_prev = 0;
    logic [63:0] snap;

    function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic s, int es,
                                logic [10:0] fa, logic [10:0] fb,
                                logic n, logic i, logic z, logic [9:0] nf);
        vec_t v;
        v.a = a; v.b = b; v.sign = s; v.es = 7'(es);
        v.fa = fa; v.fb = fb; v.nan = n; v.inf = i; v.zero = z; v.nf = nf;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {17'b0, bus.sign_out, bus.exp_sum, bus.frac_a, bus.frac_b,
                bus.is_nan, bus.is_inf, bus.is_zero, bus.nan_frac, bus.tag_out};
    endfunction

    // Monitor: pops the scoreboard on every output transfer and checks hold-during-stall.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_stable", outs(), snap);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got tag 0x%0h expected no output", bus.tag_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("tag",      64'(bus.tag_out),  64'(e.tag));
                    chk("sign",     64'(bus.sign_out), 64'(e.v.sign));
                    chk("exp_sum",  64'(bus.exp_sum),  64'(e.v.es));
                    chk("frac_a",   64'(bus.frac_a),   64'(e.v.fa));
                    chk("frac_b",   64'(bus.frac_b),   64'(e.v.fb));
                    chk("is_nan",   64'(bus.is_nan),   64'(e.v.nan));
                    chk("is_inf",   64'(bus.is_inf),   64'(e.v.inf));
                    chk("is_zero",  64'(bus.is_zero),  64'(e.v.zero));
                    chk("nan_frac", 64'(bus.nan_frac), 64'(e.v.nf));
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            snap       = outs();
        end
    end

    // Random downstream readiness during the long run.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Call just after a rising edge; returns just after the edge that accepted the op.
    task automatic send(int idx, logic [3:0] tag, output int waits);
        exp_t e;
        waits      = 0;
        bus.in_valid = 1'b1;
        bus.a_in     = vecs[idx].a;
        bus.b_in     = vecs[idx].b;
        bus.tag_in   = tag;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.v = vecs[idx];
                e.tag = tag;
                q.push_back(e);
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            waits++;
            if (waits > 500) begin
                chk("send_timeout", 64'(waits), 64'd0);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int w;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b0;

        vecs[0] = mk(16'h3C00, 16'h4000, 0, 16,  11'h400, 11'h400, 0, 0, 0, 10'h000);
        vecs[1] = mk(16'h7C00, 16'h8000, 1, 17,  11'h400, 11'h000, 1, 0, 0, 10'h200);
        vecs[2] = mk(16'hFC00, 16'h3C00, 1, 31,  11'h400, 11'h400, 0, 1, 0, 10'h000);
        vecs[3] = mk(16'h3C00, 16'h7C05, 0, 31,  11'h400, 11'h405, 1, 0, 0, 10'h205);
        vecs[4] = mk(16'h7D01, 16'h7C05, 0, 47,  11'h501, 11'h405, 1, 0, 0, 10'h301);
`ifdef FPMUL_UNPACK_FTZ_EN
        vecs[5] = mk(16'h0001, 16'h0001, 0, -13, 11'h000, 11'h000, 0, 0, 1, 10'h000);
        vecs[8] = mk(16'h7C00, 16'h0001, 0, 17,  11'h400, 11'h000, 1, 0, 0, 10'h200);
`else
        vecs[5] = mk(16'h0001, 16'h0001, 0, -13, 11'h001, 11'h001, 0, 0, 0, 10'h000);
        vecs[8] = mk(16'h7C00, 16'h0001, 0, 17,  11'h400, 11'h001, 0, 1, 0, 10'h000);
`endif
        vecs[6] = mk(16'h7BFF, 16'h7BFF, 0, 45,  11'h7FF, 11'h7FF, 0, 0, 0, 10'h000);
        vecs[7] = mk(16'h8000, 16'hC000, 0, 2,   11'h000, 11'h400, 0, 0, 1, 10'h000);
        vecs[9] = mk(16'hBC00, 16'h7E00, 1, 31,  11'h400, 11'h600, 1, 0, 0, 10'h200);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_data",      outs(),             64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors, back-to-back, downstream always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(i, 4'(i + 5), w);
            chk("stream_wait", 64'(w), 64'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("stream_drained", 64'(q.size()), 64'd0);

        // Backpressure: two accepted, then in_ready drops until downstream resumes
        bus.out_ready = 1'b0;
        send(0, 4'hA, w);
        chk("bp_acc1_wait", 64'(w), 64'd0);
        send(1, 4'hB, w);
        chk("bp_acc2_wait", 64'(w), 64'd0);
        fork
            begin
                send(2, 4'hC, w);
                send(3, 4'hD, w);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", 64'(bus.in_ready),  64'd0);
                    chk("bp_out_valid",    64'(bus.out_valid), 64'd1);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Reset with output and skid both full; input held valid during reset
        bus.out_ready = 1'b0;
        send(4, 4'h1, w);
        send(5, 4'h2, w);
        @(negedge clk);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a_in     = vecs[6].a;
        bus.b_in     = vecs[6].b;
        bus.tag_in   = 4'h3;
        rst          = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("mrst_data",      outs(),             64'd0);
        @(posedge clk);
        #1;
        q.delete();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("mrst_no_output", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Long run with random gaps and random downstream readiness
        rand_rdy = 1;
        for (int i = 0; i < 1000; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            if (gap != 0) #1;
            send($urandom_range(0, 9), 4'(i), w);
        end
        rand_rdy = 0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        chk("final_drained", 64'(q.size()), 64'd0);
        chk("final_idle",    64'(bus.out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
